pc_fetch_sequencer: RTL and testbench
=====================================

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded at reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum cycles spent in REQ without imem_ack; legal range 1..255.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetl, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, instruction-fetch request.
REQ-006 SHALL have port imem_addr, output, 64, fetch address.
REQ-007 SHALL have port imem_ack, input, 1, fetch data valid this cycle.
REQ-008 SHALL have port imem_rdata, input, 32, fetched instruction.
REQ-009 SHALL have port CurrentPC, output, 64, PC of the held instruction.
REQ-010 SHALL have port Instruction, output, 32, the held instruction.
REQ-011 SHALL have port inst_valid, output, 1, meaning Instruction/CurrentPC are presented to the datapath.
REQ-012 SHALL have port retire, input, 1, meaning the datapath has finished the presented instruction.
REQ-013 SHALL have ports Branch, Uncondbranch and ALUZero, each input, 1, the branch controls sampled at retire.
REQ-014 SHALL have port SignExtImm64, input, 64, the word-offset branch immediate sampled at retire.
REQ-015 SHALL have port fetch_err, output, 1, sticky fetch-timeout flag.
REQ-016 SHALL have port retired_count, output, 32, the count of retired instructions.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, EXEC and ERR.
REQ-018 IDLE SHALL go to REQ unconditionally one cycle after reset release.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal CurrentPC; imem_req SHALL be 0 in every other state.
REQ-020 In REQ with imem_ack=1, the block SHALL latch imem_rdata into Instruction, clear the timeout counter and go to EXEC.
REQ-021 In REQ with imem_ack=0, the timeout counter SHALL increment; when it reaches ACK_TIMEOUT the block SHALL go to ERR and set fetch_err.
REQ-022 When imem_ack=1 and the timeout is reached in the same cycle, ack SHALL win.
REQ-023 inst_valid SHALL be 1 only in EXEC; Instruction and CurrentPC SHALL be stable throughout EXEC.
REQ-024 In EXEC with retire=1, the block SHALL load CurrentPC with the next PC, increment retired_count and go to REQ.
REQ-025 The next PC SHALL be CurrentPC+(SignExtImm64<<2) when (Uncondbranch | (Branch & ALUZero)), and CurrentPC+4 otherwise.
REQ-026 The next PC SHALL wrap modulo 2^64, and retired_count SHALL wrap modulo 2^32.
REQ-027 retire in IDLE, REQ or ERR SHALL be ignored; imem_ack outside REQ SHALL be ignored.
REQ-028 ERR SHALL be terminal until reset: imem_req=0, inst_valid=0, fetch_err=1, and all outputs held.
REQ-029 Fetch-to-issue latency SHALL be one cycle after the ack edge; retire-to-next-request latency SHALL be one cycle.

Reset
REQ-030 While resetl=0 (asynchronous), state SHALL be IDLE, CurrentPC=RESET_PC, Instruction=0, imem_addr=RESET_PC, imem_req=0, inst_valid=0, fetch_err=0, retired_count=0 and the timeout counter=0.
REQ-031 Reset asserted mid-fetch or mid-EXEC SHALL abandon the transaction; a late imem_ack after reset SHALL be ignored unless the block is in REQ.

Structure
REQ-032 A shared package SHALL hold the state encoding (2-bit), the PC width (64), the instruction width (32) and the PC increment constant (4).
REQ-033 The next-PC selection SHALL be one combinational sub-module, pc_target_calc, instantiated once.

Verification
REQ-034 Reset release, then ack on the 3rd REQ cycle with 32'hF84003E9 -> imem_addr=0, then inst_valid=1, Instruction=F84003E9, CurrentPC=0.
REQ-035 retire with Branch=0, Uncondbranch=0 at PC=0x10 -> next imem_addr=0x14 and retired_count increments by 1.
REQ-036 retire with Branch=1, ALUZero=1, SignExtImm64=-2 at PC=0x10 -> next imem_addr=0x08; with ALUZero=0 -> 0x14.
REQ-037 With no ack for ACK_TIMEOUT=4 cycles -> ERR and fetch_err=1 stays set; a later retire or ack produces no change.
REQ-038 Ack and the timeout limit in the same cycle -> EXEC with fetch_err=0; PC=0xFFFF_FFFF_FFFF_FFFC with a plain retire -> next imem_addr=0.
REQ-039 resetl pulsed low during EXEC -> all outputs immediately take their REQ-030 values, and a stray retire in IDLE is ignored.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer_pkg
// Description : Shared types and constants for the PC fetch sequencer:
//               FSM state encoding, PC/instruction widths and PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_sequencer_pkg;

    localparam int c_pc_width   = 64;
    localparam int c_inst_width = 32;

    // Sequential fall-through step: one 32-bit instruction word.
    localparam logic [c_pc_width-1:0] c_pc_inc = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

endpackage : pc_fetch_sequencer_pkg
`default_nettype wire

// File: rtl/pc_fetch_sequencer_target.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational next-PC selection. Takes the branch target
//               (PC + word offset * 4) when the branch is unconditional or
//               conditional-and-taken, otherwise PC + 4. Wraps modulo 2^64.
// Ports       : i_current_pc   - PC of the retiring instruction
//               i_imm          - sign-extended word-offset immediate
//               i_branch       - conditional branch
//               i_uncondbranch - unconditional branch
//               i_aluzero      - ALU zero flag (condition for i_branch)
//               o_next_pc      - selected next PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [c_pc_width-1:0] i_current_pc,
    input  logic [c_pc_width-1:0] i_imm,
    input  logic                  i_branch,
    input  logic                  i_uncondbranch,
    input  logic                  i_aluzero,
    output logic [c_pc_width-1:0] o_next_pc
);

    logic w_taken;

    assign w_taken   = i_uncondbranch | (i_branch & i_aluzero);
    assign o_next_pc = w_taken ? (i_current_pc + (i_imm << 2))
                               : (i_current_pc + c_pc_inc);

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Instruction-fetch sequencer. Requests the instruction at
//               CurrentPC, holds it for the datapath until retire, then
//               advances the PC (sequential or branch). A fetch that sees no
//               ack within ACK_TIMEOUT cycles parks the block in a terminal
//               error state until reset.
// Ports       : CLK, resetl            - clock, async active-low reset
//               imem_req/addr/ack/rdata- instruction memory handshake
//               CurrentPC, Instruction - held instruction and its PC
//               inst_valid, retire     - datapath handshake
//               Branch, Uncondbranch, ALUZero, SignExtImm64 - branch controls
//               fetch_err              - sticky fetch-timeout flag
//               retired_count          - retired instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    resetl,
    output logic                    imem_req,
    output logic [c_pc_width-1:0]   imem_addr,
    input  logic                    imem_ack,
    input  logic [c_inst_width-1:0] imem_rdata,
    output logic [c_pc_width-1:0]   CurrentPC,
    output logic [c_inst_width-1:0] Instruction,
    output logic                    inst_valid,
    input  logic                    retire,
    input  logic                    Branch,
    input  logic                    Uncondbranch,
    input  logic                    ALUZero,
    input  logic [c_pc_width-1:0]   SignExtImm64,
    output logic                    fetch_err,
    output logic [31:0]             retired_count
);

    // 9 bits so that counter+1 never overflows against a limit of up to 255.
    localparam logic [8:0] c_tmo_limit = ACK_TIMEOUT[8:0];

    fetch_state_t            r_state;
    fetch_state_t            w_next_state;
    logic [c_pc_width-1:0]   r_pc;
    logic [c_inst_width-1:0] r_instr;
    logic [7:0]              r_tmo;
    logic                    r_err;
    logic [31:0]             r_count;

    logic                    w_load_instr;
    logic                    w_tmo_clr;
    logic                    w_tmo_inc;
    logic                    w_set_err;
    logic                    w_load_pc;
    logic                    w_tmo_hit;
    logic [c_pc_width-1:0]   w_next_pc;

    pc_target_calc u_target (
        .i_current_pc   (r_pc),
        .i_imm          (SignExtImm64),
        .i_branch       (Branch),
        .i_uncondbranch (Uncondbranch),
        .i_aluzero      (ALUZero),
        .o_next_pc      (w_next_pc)
    );

    // Limit is reached by the increment this cycle would perform.
    assign w_tmo_hit = ({1'b0, r_tmo} + 9'd1) >= c_tmo_limit;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_instr = 1'b0;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        w_set_err    = 1'b0;
        w_load_pc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_REQ;
            end
            ST_REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (imem_ack) begin
                    w_load_instr = 1'b1;
                    w_tmo_clr    = 1'b1;
                    w_next_state = ST_EXEC;
                end else begin
                    w_tmo_inc = 1'b1;
                    if (w_tmo_hit) begin
                        w_set_err    = 1'b1;
                        w_next_state = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                if (retire) begin
                    w_load_pc    = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + 8'd1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_load_pc) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign imem_req      = (r_state == ST_REQ);
    assign inst_valid    = (r_state == ST_EXEC);
    assign imem_addr     = r_pc;
    assign CurrentPC     = r_pc;
    assign Instruction   = r_instr;
    assign fetch_err     = r_err;
    assign retired_count = r_count;

endmodule : pc_fetch_sequencer
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Scoreboard bench for pc_fetch_sequencer. Stimulus pushes the
//               expected request / issue / error events; a monitor pops and
//               compares them as the DUT raises imem_req, inst_valid or
//               fetch_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        retire = 1'b0;
    logic        Branch = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        ALUZero = 1'b0;
    logic [63:0] SignExtImm64 = 64'h0;
    logic        fetch_err;
    logic [31:0] retired_count;

    pc_fetch_sequencer #(
        .RESET_PC    (64'h0),
        .ACK_TIMEOUT (4)
    ) dut (
        .CLK           (CLK),
        .resetl        (resetl),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .CurrentPC     (CurrentPC),
        .Instruction   (Instruction),
        .inst_valid    (inst_valid),
        .retire        (retire),
        .Branch        (Branch),
        .Uncondbranch  (Uncondbranch),
        .ALUZero       (ALUZero),
        .SignExtImm64  (SignExtImm64),
        .fetch_err     (fetch_err),
        .retired_count (retired_count)
    );

    always #5 CLK = ~CLK;

    // kind: 0 = new request, 1 = instruction issued, 2 = error entered
    typedef struct {
        int          kind;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_pc  = 64'h0;
    logic [31:0] m_cnt = 32'h0;
    logic [31:0] m_ins = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic no_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with empty scoreboard, got 1 event, expected 0", name);
    endtask

    // ---------------- monitor ----------------
    initial begin : mon
        logic        p_req, p_val, p_err;
        logic [63:0] h_pc;
        logic [31:0] h_ins;
        exp_t        e;
        p_req = 1'b0; p_val = 1'b0; p_err = 1'b0;
        h_pc = '0; h_ins = '0;
        forever begin
            @(negedge CLK);
            if (imem_req && !p_req) begin
                if (q.size() == 0) no_event("req_event");
                else begin
                    e = q.pop_front();
                    chk("req_kind", 64'(e.kind), 64'd0);
                    chk("req_addr", imem_addr, e.pc);
                    chk("req_pc", CurrentPC, e.pc);
                    chk("req_count", 64'(retired_count), 64'(e.cnt));
                    chk("req_err", 64'(fetch_err), 64'd0);
                end
            end
            if (inst_valid && !p_val) begin
                if (q.size() == 0) no_event("issue_event");
                else begin
                    e = q.pop_front();
                    chk("issue_kind", 64'(e.kind), 64'd1);
                    chk("issue_pc", CurrentPC, e.pc);
                    chk("issue_instr", 64'(Instruction), 64'(e.instr));
                    chk("issue_count", 64'(retired_count), 64'(e.cnt));
                    chk("issue_err", 64'(fetch_err), 64'd0);
                    chk("issue_req", 64'(imem_req), 64'd0);
                    h_pc  = e.pc;
                    h_ins = e.instr;
                end
            end else if (inst_valid && p_val) begin
                chk("exec_stable_pc", CurrentPC, h_pc);
                chk("exec_stable_instr", 64'(Instruction), 64'(h_ins));
            end
            if (fetch_err && !p_err) begin
                if (q.size() == 0) no_event("err_event");
                else begin
                    e = q.pop_front();
                    chk("err_kind", 64'(e.kind), 64'd2);
                    chk("err_req", 64'(imem_req), 64'd0);
                    chk("err_valid", 64'(inst_valid), 64'd0);
                    chk("err_pc", CurrentPC, e.pc);
                    chk("err_count", 64'(retired_count), 64'(e.cnt));
                end
            end
            p_req = imem_req;
            p_val = inst_valid;
            p_err = fetch_err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        chk("wait_req", 64'(imem_req), 64'd1);
    endtask

    // Ack in the k-th REQ cycle (k=1 is the cycle the request first appears).
    task automatic fetch(input int k, input logic [31:0] data);
        wait_req();
        q.push_back('{kind: 1, pc: m_pc, instr: data, cnt: m_cnt});
        m_ins = data;
        repeat (k - 1) step();
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = ~data;
    endtask

    task automatic do_retire(input logic b, input logic u, input logic z,
                             input logic [63:0] imm, input int hold,
                             input logic [63:0] exp_next);
        repeat (hold) step();
        chk("valid_before_retire", 64'(inst_valid), 64'd1);
        m_pc = exp_next;
        m_cnt++;
        q.push_back('{kind: 0, pc: m_pc, instr: 32'h0, cnt: m_cnt});
        Branch = b; Uncondbranch = u; ALUZero = z; SignExtImm64 = imm;
        retire = 1'b1;
        step();
        retire = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; ALUZero = 1'b0;
        SignExtImm64 = 64'h5A5A;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_fetch_err"}, 64'(fetch_err), 64'd0);
        chk({tag, "_pc"}, CurrentPC, 64'h0);
        chk({tag, "_addr"}, imem_addr, 64'h0);
        chk({tag, "_instr"}, 64'(Instruction), 64'd0);
        chk({tag, "_count"}, 64'(retired_count), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) step();
        chk_reset_values("reset");

        // Release; first request at 0, ack on the 3rd REQ cycle.
        q.push_back('{kind: 0, pc: 64'h0, instr: 32'h0, cnt: 32'h0});
        resetl = 1'b1;
        fetch(3, 32'hF84003E9);

        do_retire(0, 0, 0, 64'h0, 0, 64'h4);
        fetch(1, 32'h8B020020);
        do_retire(0, 0, 0, 64'h0, 2, 64'h8);
        fetch(2, 32'h11111111);
        do_retire(1, 0, 0, 64'd5, 0, 64'hC);                 // branch not taken
        fetch(1, 32'h22222222);
        do_retire(0, 0, 1, 64'd7, 1, 64'h10);                // zero alone ignored
        fetch(1, 32'h33333333);
        do_retire(0, 0, 0, 64'h0, 0, 64'h14);                // plain at 0x10
        fetch(1, 32'h44444444);
        do_retire(1, 0, 1, -64'sd1, 0, 64'h10);              // back to 0x10
        fetch(1, 32'h55555555);
        do_retire(1, 0, 1, -64'sd2, 0, 64'h8);               // taken, -2 words
        fetch(1, 32'h66666666);
        do_retire(0, 1, 0, 64'd2, 0, 64'h10);                // unconditional
        fetch(1, 32'h77777777);
        do_retire(1, 0, 0, -64'sd2, 0, 64'h14);              // not taken at 0x10
        fetch(1, 32'h88888888);
        do_retire(0, 1, 0, -64'sd6, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(4, 32'h99999999);                              // ack on timeout cycle
        do_retire(0, 0, 0, 64'h0, 1, 64'h0);                 // wraps to 0
        fetch(1, 32'hAAAAAAAA);

        // Reset pulse during EXEC, with stray retire and ack around it.
        step();
        resetl = 1'b0;
        #1;
        chk_reset_values("midexec_reset");
        retire   = 1'b1;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        m_pc  = 64'h0;
        m_cnt = 32'h0;
        q.push_back('{kind: 0, pc: 64'h0, instr: 32'h0, cnt: 32'h0});
        resetl = 1'b1;
        step();                                              // IDLE with retire=1
        retire = 1'b0;
        fetch(2, 32'hBBBBBBBB);
        do_retire(0, 0, 0, 64'h0, 0, 64'h4);

        // No ack: ERR after exactly 4 REQ cycles.
        wait_req();
        q.push_back('{kind: 2, pc: 64'h4, instr: 32'h0, cnt: 32'h1});
        repeat (3) step();
        chk("tmo_req_still", 64'(imem_req), 64'd1);
        chk("tmo_err_not_yet", 64'(fetch_err), 64'd0);
        step();
        chk("tmo_err_set", 64'(fetch_err), 64'd1);
        retire     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCCCCCCCC;
        repeat (5) step();
        retire   = 1'b0;
        imem_ack = 1'b0;
        chk("err_sticky", 64'(fetch_err), 64'd1);
        chk("err_hold_req", 64'(imem_req), 64'd0);
        chk("err_hold_valid", 64'(inst_valid), 64'd0);
        chk("err_hold_pc", CurrentPC, 64'h4);
        chk("err_hold_addr", imem_addr, 64'h4);
        chk("err_hold_instr", 64'(Instruction), 64'(m_ins));
        chk("err_hold_count", 64'(retired_count), 64'd1);

        repeat (2) step();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_fetch_sequencer
`default_nettype wire
